seq_alu_core: RTL and testbench
===============================

// Module: seq_alu_core
// PURPOSE
//  Sequential ALU that consumes the secondary operand selected by the 4:1 data-source mux.
//  Holds the processor accumulator and Z/C/N flags.
//  Executes one operation per start request: single-cycle logic/arith ops, or an optional
//  iterative multiply.
//  Sits directly downstream of the operand mux; acc_out feeds back as the primary operand and writeback source.
// PARAMETERS
//  DataWidth  8  width of accumulator, operand and result (>=2)
// PORTS
//  clk      in   1          single clock, rising edge
//  rst      in   1          asynchronous, active-high reset
//  start    in   1          request: execute op on operand; accepted only when busy=0
//  op       in   3          opcode (alu_pkg::alu_op_e), sampled with start
//  operand  in   DataWidth  secondary operand from the data-source mux, sampled with start
//  acc_out  out  DataWidth  accumulator value
//  flag_z   out  1          result==0
//  flag_c   out  1          carry/borrow/shift-out/overflow (per op)
//  flag_n   out  1          result MSB
//  busy     out  1          multi-cycle op in progress
//  done     out  1          one-cycle pulse: result and flags just committed
// BEHAVIOUR
//  Reset (async, rst=1):
//   acc_out, flag_z, flag_c, flag_n, busy and done all go to 0; state goes to IDLE.
//   Any in-progress op is discarded; no done pulse is generated.
//  States: IDLE, MUL. Accept = start & ~busy at a rising edge T.
//  Single-cycle ops (IDLE->IDLE): acc, flags and done=1 are valid after edge T; done drops after T+1.
//  Opcodes:
//   0 LOAD  acc=operand, C=0
//   1 ADD   acc=acc+operand, C=carry out of MSB
//   2 SUB   acc=acc-operand, C=borrow (1 iff acc<operand, unsigned)
//   3 AND, 4 OR, 5 XOR  bitwise, C=0
//   6 SHL   acc=acc<<1, C=old acc MSB; operand ignored
//   7 MUL   see CONFIGURATION
//  Z and N are computed from the committed result on every op.
//  Arithmetic is modulo 2^DataWidth.
//  start while busy=1 is ignored entirely: no queuing and no effect on op/operand.
//  start held high: a new op is accepted at every edge where busy=0, including the done cycle of MUL.
//  op and operand may change freely when not being accepted.
// CONFIGURATION
//  Macro ALU_MUL_EN defined:
//   Edge T: capture multiplicand=acc and multiplier=operand; clear the 2*DataWidth product
//    and the iteration counter; go to MUL; busy=1.
//   MUL performs one shift-add iteration per cycle, DataWidth iterations in total.
//   After edge T+DataWidth:
//    acc = product[DataWidth-1:0]
//    C = |product[2*DataWidth-1:DataWidth] (overflow)
//    Z and N from acc
//    done=1, busy=0, state IDLE
//   acc_out and flags hold their pre-MUL values while busy.
//  Macro ALU_MUL_EN undefined:
//   op 7 is a single-cycle NOP: acc and flags unchanged, done pulses after T, busy stays 0.
//   No multiplier logic is synthesised.
// STRUCTURE
//  Package alu_pkg:
//   alu_op_e (3-bit enum LOAD..MUL)
//   alu_state_e (IDLE, MUL)
//   ALU_DW_DEFAULT=8
//  Sub-module alu_mul_iter (only under ALU_MUL_EN):
//   shift-add datapath with load/step inputs and product and last outputs.
//   seq_alu_core owns the FSM, the accumulator and the flags.
// TESTING
//  1. rst pulse mid-cycle, no clk edge -> all outputs 0 immediately; busy=0.
//  2. LOAD 0x05 then ADD 0xFB -> acc=0x00, Z=1, C=1, N=0; done on each op's following cycle.
//  3. LOAD 0x02, SUB 0x03 -> acc=0xFF, C=1, N=1, Z=0.
//     Then SHL -> acc=0xFE, C=1.
//  4. MUL_EN:
//     LOAD 0x0D, MUL 0x0B -> busy high for 8 cycles, then acc=0x8F, C=0, N=1, done one cycle.
//     LOAD 0x20, MUL 0x10 -> acc=0x00, C=1, Z=1.
//  5. MUL_EN, start=1 with op=LOAD 0x55 during busy -> ignored; MUL result is committed.
//     With start held, LOAD is accepted on the done cycle, then acc=0x55.
//  6. rst asserted 3 cycles into a MUL -> acc=0, busy=0, no done.
//     Without ALU_MUL_EN: op 7 -> acc and flags unchanged, done pulses, busy never 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

    localparam int ALU_DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_MUL  = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, DataWidth steps.
module alu_mul_iter #(
    parameter int DataWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic [DataWidth-1:0]     mcand_i,
    input  logic [DataWidth-1:0]     mplier_i,
    output logic [2*DataWidth-1:0]   product_o,
    output logic                     last_o
);

    localparam int CntW = $clog2(DataWidth);

    logic [2*DataWidth-1:0] mcand_q;
    logic [DataWidth-1:0]   mplier_q;
    logic [2*DataWidth-1:0] prod_q;
    logic [2*DataWidth-1:0] prod_d;
    logic [CntW-1:0]        cnt_q;

    // product_o is the value after the current step, so the owner can commit on the last step
    assign prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign product_o = prod_d;
    assign last_o    = step_i && (cnt_q == CntW'(DataWidth - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            mcand_q  <= {{DataWidth{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            prod_q   <= '0;
        end else if (step_i) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU with accumulator and Z/C/N flags; one op per accepted start.
// Define ALU_MUL_EN to build the iterative multiplier for op 7 (otherwise op 7 is a NOP).
module seq_alu_core
    import alu_pkg::*;
#(
    parameter int DataWidth = ALU_DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DataWidth-1:0] operand,
    output logic [DataWidth-1:0] acc_out,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_n,
    output logic                 busy,
    output logic                 done
);

    alu_state_e             state_q;
    alu_op_e                op_e;
    logic [DataWidth-1:0]   acc_q;
    logic                   z_q, c_q, n_q, busy_q, done_q;
    logic [DataWidth-1:0]   res_d;
    logic                   c_d;
    logic [DataWidth:0]     wide_d;

    assign op_e = alu_op_e'(op);

    always_comb begin
        res_d  = acc_q;
        c_d    = 1'b0;
        wide_d = '0;
        unique case (op_e)
            OP_LOAD: res_d = operand;
            OP_ADD: begin
                wide_d = {1'b0, acc_q} + {1'b0, operand};
                res_d  = wide_d[DataWidth-1:0];
                c_d    = wide_d[DataWidth];
            end
            OP_SUB: begin
                // top bit of the extended difference is the unsigned borrow
                wide_d = {1'b0, acc_q} - {1'b0, operand};
                res_d  = wide_d[DataWidth-1:0];
                c_d    = wide_d[DataWidth];
            end
            OP_AND: res_d = acc_q & operand;
            OP_OR:  res_d = acc_q | operand;
            OP_XOR: res_d = acc_q ^ operand;
            OP_SHL: begin
                res_d = {acc_q[DataWidth-2:0], 1'b0};
                c_d   = acc_q[DataWidth-1];
            end
            default: begin
                res_d = acc_q;
                c_d   = c_q;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*DataWidth-1:0] mul_prod;
    logic                   mul_last;
    logic                   mul_load;

    assign mul_load = start && (state_q == ST_IDLE) && (op_e == OP_MUL);

    alu_mul_iter #(.DataWidth(DataWidth)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load_i    (mul_load),
        .step_i    (state_q == ST_MUL),
        .mcand_i   (acc_q),
        .mplier_i  (operand),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op_e == OP_MUL) begin
`ifdef ALU_MUL_EN
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
`else
                            done_q  <= 1'b1;
`endif
                        end else begin
                            acc_q  <= res_d;
                            c_q    <= c_d;
                            z_q    <= (res_d == '0);
                            n_q    <= res_d[DataWidth-1];
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
`ifdef ALU_MUL_EN
                    if (mul_last) begin
                        acc_q   <= mul_prod[DataWidth-1:0];
                        c_q     <= |mul_prod[2*DataWidth-1:DataWidth];
                        z_q     <= (mul_prod[DataWidth-1:0] == '0);
                        n_q     <= mul_prod[DataWidth-1];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`else
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc_out = acc_q;
    assign flag_z  = z_q;
    assign flag_c  = c_q;
    assign flag_n  = n_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core with an expected-result queue; MUL steps need ALU_MUL_EN.
module tb_seq_alu_core;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] operand = '0;
    logic [W-1:0] acc_out;
    logic         flag_z, flag_c, flag_n, busy, done;

    typedef struct packed {
        logic [W-1:0] acc;
        logic         z;
        logic         c;
        logic         n;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_acc = '0;
    logic         m_z = 1'b0, m_c = 1'b0, m_n = 1'b0;
    logic [W-1:0] pre_acc = '0;
    int           checks = 0;
    int           errors = 0;
    int           nb;

    seq_alu_core #(.DataWidth(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .acc_out (acc_out),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_n  (flag_n),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
        sb.delete();
    endtask

    task automatic push_op(input logic [2:0] o, input logic [W-1:0] v);
        logic [W:0]     t;
        logic [2*W-1:0] p;
        pre_acc = m_acc;
        case (o)
            3'd0: begin m_acc = v; m_c = 1'b0; end
            3'd1: begin t = {1'b0, m_acc} + {1'b0, v}; m_acc = t[W-1:0]; m_c = t[W]; end
            3'd2: begin m_c = (m_acc < v); m_acc = m_acc - v; end
            3'd3: begin m_acc = m_acc & v; m_c = 1'b0; end
            3'd4: begin m_acc = m_acc | v; m_c = 1'b0; end
            3'd5: begin m_acc = m_acc ^ v; m_c = 1'b0; end
            3'd6: begin m_c = m_acc[W-1]; m_acc = m_acc << 1; end
            default: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, m_acc} * {{W{1'b0}}, v};
                m_acc = p[W-1:0];
                m_c = |p[2*W-1:W];
`endif
            end
        endcase
`ifdef ALU_MUL_EN
        m_z = (m_acc == '0); m_n = m_acc[W-1];
`else
        if (o != 3'd7) begin m_z = (m_acc == '0); m_n = m_acc[W-1]; end
`endif
        sb.push_back('{acc: m_acc, z: m_z, c: m_c, n: m_n});
    endtask

    // Called at a negedge; returns at the following negedge with start released.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] v);
        start = 1'b1; op = o; operand = v;
        push_op(o, v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int nbusy);
        bit   got;
        exp_t e;
        got = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin got = 1; break; end
            if (busy === 1'b1) begin
                nbusy++;
                chk({tag, "_hold"}, acc_out, pre_acc);
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, got, 1);
        if (got) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_acc"}, acc_out, e.acc);
                chk({tag, "_z"}, flag_z, e.z);
                chk({tag, "_c"}, flag_c, e.c);
                chk({tag, "_n"}, flag_n, e.n);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] v);
        issue(o, v);
        wait_done(tag, nb);
        @(negedge clk);
        chk({tag, "_done_drop"}, done, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acc"}, acc_out, 0);
        chk({tag, "_z"}, flag_z, 0);
        chk({tag, "_c"}, flag_c, 0);
        chk({tag, "_n"}, flag_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int ndone, nbusy;
        // power-up async reset with no clock edge in the window
        #1 rst = 1'b1;
        #1 chk_all_zero("rst0");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        run_op("t2_load", 3'd0, 8'h05);
        run_op("t2_add", 3'd1, 8'hFB);
        chk("t2_acc_lit", acc_out, 8'h00);
        chk("t2_zcn_lit", {flag_z, flag_c, flag_n}, 3'b110);

        run_op("t3_load", 3'd0, 8'h02);
        run_op("t3_sub", 3'd2, 8'h03);
        chk("t3_sub_lit", {acc_out, flag_z, flag_c, flag_n}, {8'hFF, 3'b011});
        run_op("t3_shl", 3'd6, 8'h00);
        chk("t3_shl_lit", {acc_out, flag_c}, {8'hFE, 1'b1});

        // reset pulse between edges clears everything immediately
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);

        run_op("lg_load", 3'd0, 8'hF0);
        run_op("lg_and", 3'd3, 8'h3C);
        run_op("lg_or", 3'd4, 8'h0F);
        run_op("lg_xor", 3'd5, 8'hFF);
        chk("lg_xor_lit", acc_out, 8'hC0);
        run_op("ad_nc", 3'd1, 8'h01);
        run_op("sub_nb", 3'd2, 8'h41);
        chk("sub_nb_lit", {acc_out, flag_z, flag_c}, {8'h80, 2'b00});

`ifdef ALU_MUL_EN
        run_op("t4_load", 3'd0, 8'h0D);
        issue(3'd7, 8'h0B);
        wait_done("t4_mul", nbusy);
        chk("t4_busy_cycles", nbusy, W);
        chk("t4_mul_lit", {acc_out, flag_c, flag_n}, {8'h8F, 2'b01});
        @(negedge clk);
        chk("t4_done_drop", done, 0);

        run_op("t4b_load", 3'd0, 8'h20);
        run_op("t4b_mul", 3'd7, 8'h10);
        chk("t4b_mul_lit", {acc_out, flag_z, flag_c}, {8'h00, 2'b11});

        // start held through MUL with a LOAD presented while busy
        run_op("t5_load", 3'd0, 8'h03);
        start = 1'b1; op = 3'd7; operand = 8'h05;
        push_op(3'd7, 8'h05);
        @(posedge clk);
        @(negedge clk);
        op = 3'd0; operand = 8'h55;
        wait_done("t5_mul", nbusy);
        chk("t5_busy_cycles", nbusy, W);
        chk("t5_mul_lit", acc_out, 8'h0F);
        push_op(3'd0, 8'h55);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_load2", nbusy);
        chk("t5_load_lit", acc_out, 8'h55);
        @(negedge clk);

        // reset in the middle of a MUL discards it
        run_op("t6_load", 3'd0, 8'h07);
        start = 1'b1; op = 3'd7; operand = 8'h09;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("t6_rst");
        #1 rst = 1'b0;
        model_reset();
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        chk("t6_no_done", ndone, 0);
        chk("t6_no_busy", nbusy, 0);
        run_op("t6_recover", 3'd0, 8'h3A);
`else
        // op 7 is a single-cycle NOP: flags survive, busy never rises
        run_op("t6_load", 3'd0, 8'hF0);
        run_op("t6_add", 3'd1, 8'h20);
        issue(3'd7, 8'h99);
        wait_done("t6_nop", nbusy);
        chk("t6_nop_busy", nbusy, 0);
        chk("t6_nop_busy_now", busy, 0);
        chk("t6_nop_lit", {acc_out, flag_z, flag_c, flag_n}, {8'h10, 3'b010});
        @(negedge clk);
        chk("t6_nop_drop", done, 0);
        // after reset Z=0 with acc=0; a NOP must not recompute it
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_op("t6_nop_rst", 3'd7, 8'h00);
        chk("t6_nop_rst_z", flag_z, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
